// File: rtl/uart_byte_tx_if.sv
// Byte-in / serial-out bundle of the UART transmitter.
// The master supplies bytes; the slave drives the line and status flags.
interface uart_byte_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 UART transmitter with a one-entry holding buffer.
// A queued byte starts its frame on the edge that ends the previous frame.
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input logic         clk,
  input logic         rst,
  uart_byte_tx_if.slave bus
);

  if (CLKS_PER_BIT < 2) begin : g_badClksPerBit
    $error("uart_byte_tx: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_badStopBits
    $error("uart_byte_tx: STOP_BITS must be 1 or 2");
  end

  localparam int            BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        r_state;
  logic [BW-1:0] r_baudCnt;
  logic [2:0]    r_bitIdx;
  logic          r_stopCnt;
  logic [7:0]    r_shift;
  logic [7:0]    r_buf;
  logic          r_bufFull;
  logic          r_tx;

  state_t        w_stateNext;
  logic [BW-1:0] w_baudNext;
  logic [2:0]    w_bitNext;
  logic          w_stopNext;
  logic [7:0]    w_shiftNext;
  logic [7:0]    w_bufNext;
  logic          w_bufFullNext;
  logic          w_txNext;
  logic          w_bitEnd;
  logic          w_frameEnd;
  logic          w_accept;
  logic          w_bypass;

  assign w_accept   = bus.tx_valid && !r_bufFull;
  assign w_bitEnd   = (r_baudCnt == BAUD_LAST);
  assign w_frameEnd = (r_state == STOP) && w_bitEnd && (r_stopCnt == STOP_LAST);
  // A byte skips the buffer whenever the shifter is free on this very edge.
  assign w_bypass   = w_accept && ((r_state == IDLE) || w_frameEnd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_baudCnt <= '0;
      r_bitIdx  <= '0;
      r_stopCnt <= 1'b0;
      r_shift   <= '0;
      r_buf     <= '0;
      r_bufFull <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_stateNext;
      r_baudCnt <= w_baudNext;
      r_bitIdx  <= w_bitNext;
      r_stopCnt <= w_stopNext;
      r_shift   <= w_shiftNext;
      r_buf     <= w_bufNext;
      r_bufFull <= w_bufFullNext;
      r_tx      <= w_txNext;
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    w_baudNext    = w_bitEnd ? '0 : r_baudCnt + BW'(1);
    w_bitNext     = r_bitIdx;
    w_stopNext    = r_stopCnt;
    w_shiftNext   = r_shift;
    w_bufNext     = r_buf;
    w_bufFullNext = r_bufFull;
    case (r_state)
      IDLE: begin
        w_baudNext = '0;
        if (w_bypass) begin
          w_stateNext = START;
          w_shiftNext = bus.tx_data;
        end
      end
      START: begin
        if (w_bitEnd) begin
          w_stateNext = DATA;
          w_bitNext   = '0;
        end
      end
      DATA: begin
        if (w_bitEnd) begin
          if (r_bitIdx == 3'd7) begin
            w_stateNext = STOP;
            w_stopNext  = 1'b0;
          end else begin
            w_bitNext   = r_bitIdx + 3'd1;
            w_shiftNext = {1'b0, r_shift[7:1]};
          end
        end
      end
      STOP: begin
        if (w_frameEnd) begin
          if (r_bufFull) begin
            w_stateNext   = START;
            w_shiftNext   = r_buf;
            w_bufFullNext = 1'b0;
          end else if (w_bypass) begin
            w_stateNext = START;
            w_shiftNext = bus.tx_data;
          end else begin
            w_stateNext = IDLE;
          end
        end else if (w_bitEnd) begin
          w_stopNext = 1'b1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
    if (w_accept && !w_bypass) begin
      w_bufNext     = bus.tx_data;
      w_bufFullNext = 1'b1;
    end
  end

  // The line level is computed from the next state so tx is a clean register.
  always_comb begin
    w_txNext = 1'b1;
    case (w_stateNext)
      START:   w_txNext = 1'b0;
      DATA:    w_txNext = w_shiftNext[0];
      default: w_txNext = 1'b1;
    endcase
    bus.tx       = r_tx;
    bus.tx_done  = w_frameEnd;
    bus.tx_busy  = (r_state != IDLE);
    bus.tx_ready = !r_bufFull;
  end

endmodule
